cursor_nav_fsm: RTL and testbench

Parametrised successor to the single-byte PS/2 movement decoder. Consumes the scan-code byte stream (`data`/`data_en`) from the PS/2 receiver and decodes WASD keys, extended arrow keys (E0-prefixed), and both Enter keys. It drives a bounded grid cursor (clamp or wrap) with one-cycle move/command pulses and generates its own key-hold auto-repeat. Sits between the PS/2 receiver and the step-sequencer grid/UI logic.

---
 rtl/ps2_pkg.sv | 80 ++++++++
 rtl/ps2_code_decoder.sv | 78 +++++++
 rtl/cursor_nav_fsm.sv | 148 ++++++++++++++
 tb/tb_cursor_nav_fsm.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared definitions for the PS/2 cursor navigation block.
//   - Scan-code constants for prefixes (E0, F0) and the decoded key set.
//   - One-hot Direction encodings: [0] up, [1] down, [2] left, [3] right.
//   - Prefix-state and key-id typedefs, plus small mapping helpers.
package ps2_pkg;

  localparam logic [7:0] SC_EXT      = 8'hE0;
  localparam logic [7:0] SC_BRK      = 8'hF0;
  // Normal set (WASD + Enter)
  localparam logic [7:0] SC_W        = 8'h1D;
  localparam logic [7:0] SC_S        = 8'h1B;
  localparam logic [7:0] SC_A        = 8'h1C;
  localparam logic [7:0] SC_D        = 8'h23;
  localparam logic [7:0] SC_ENTER    = 8'h5A;
  // Extended set (arrows + keypad Enter), only meaningful after E0
  localparam logic [7:0] SC_UP       = 8'h75;
  localparam logic [7:0] SC_DOWN     = 8'h72;
  localparam logic [7:0] SC_LEFT     = 8'h6B;
  localparam logic [7:0] SC_RIGHT    = 8'h74;
  localparam logic [7:0] SC_KP_ENTER = 8'h5A;

  localparam logic [3:0] DIR_NONE  = 4'b0000;
  localparam logic [3:0] DIR_UP    = 4'b0001;
  localparam logic [3:0] DIR_DOWN  = 4'b0010;
  localparam logic [3:0] DIR_LEFT  = 4'b0100;
  localparam logic [3:0] DIR_RIGHT = 4'b1000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK
  } prefix_state_t;

  typedef enum logic [2:0] {
    KEY_NONE  = 3'd0,
    KEY_UP    = 3'd1,
    KEY_DOWN  = 3'd2,
    KEY_LEFT  = 3'd3,
    KEY_RIGHT = 3'd4,
    KEY_ENTER = 3'd5
  } key_id_t;

  // Map the final byte of a sequence to a key id; ext selects the E0 set.
  function automatic key_id_t map_key(input logic [7:0] code, input logic ext);
    key_id_t k;
    k = KEY_NONE;
    if (ext) begin
      case (code)
        SC_UP:       k = KEY_UP;
        SC_DOWN:     k = KEY_DOWN;
        SC_LEFT:     k = KEY_LEFT;
        SC_RIGHT:    k = KEY_RIGHT;
        SC_KP_ENTER: k = KEY_ENTER;
        default:     k = KEY_NONE;
      endcase
    end else begin
      case (code)
        SC_W:     k = KEY_UP;
        SC_S:     k = KEY_DOWN;
        SC_A:     k = KEY_LEFT;
        SC_D:     k = KEY_RIGHT;
        SC_ENTER: k = KEY_ENTER;
        default:  k = KEY_NONE;
      endcase
    end
    return k;
  endfunction

  function automatic logic [3:0] key_to_dir(input key_id_t k);
    case (k)
      KEY_UP:    return DIR_UP;
      KEY_DOWN:  return DIR_DOWN;
      KEY_LEFT:  return DIR_LEFT;
      KEY_RIGHT: return DIR_RIGHT;
      default:   return DIR_NONE;
    endcase
  endfunction

endpackage

// File: rtl/ps2_code_decoder.sv
// ps2_code_decoder: prefix FSM (E0 / F0 / E0 F0) and key map.
// The prefix state is registered; the key event is combinational on the
// final byte of a sequence so the top can register its outputs on the
// same edge that samples that byte.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   enable       low forces the FSM back to IDLE
//   data/data_en scan-code byte and its one-cycle valid strobe
//   key_ev       a recognised key sequence completes this cycle
//   is_break     the completing sequence is a break (F0 seen)
//   key_id       key_id_t value of the completing key
module ps2_code_decoder
  import ps2_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [7:0] data,
  input  logic       data_en,
  output logic       key_ev,
  output logic       is_break,
  output logic [2:0] key_id
);

  prefix_state_t state_q, state_d;
  logic          seq_done;
  logic          ext;
  key_id_t       key;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    seq_done = 1'b0;
    is_break = 1'b0;
    ext      = 1'b0;
    if (!enable) begin
      state_d = ST_IDLE;
    end else if (data_en) begin
      case (state_q)
        ST_IDLE: begin
          if (data == SC_EXT)      state_d = ST_EXT;
          else if (data == SC_BRK) state_d = ST_BRK;
          else                     seq_done = 1'b1;
        end
        ST_EXT: begin
          if (data == SC_BRK) begin
            state_d = ST_EXT_BRK;
          end else begin
            seq_done = 1'b1;
            ext      = 1'b1;
            state_d  = ST_IDLE;
          end
        end
        ST_BRK: begin
          seq_done = 1'b1;
          is_break = 1'b1;
          state_d  = ST_IDLE;
        end
        ST_EXT_BRK: begin
          seq_done = 1'b1;
          is_break = 1'b1;
          ext      = 1'b1;
          state_d  = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
    key    = map_key(data, ext);
    // Unknown keys finish their sequence silently: no event is raised.
    key_ev = seq_done && (key != KEY_NONE);
    key_id = key;
  end

endmodule

// File: rtl/cursor_nav_fsm.sv
// cursor_nav_fsm: PS/2 scan-code driven grid cursor with auto-repeat.
// Ports:
//   Clock, nReset  clock, asynchronous active-low reset
//   Enable         low = idle: flush decoder/held key, outputs quiet
//   data, data_en  scan-code byte stream from the PS/2 receiver
//   Direction      one-hot move pulse ([0] up [1] down [2] left [3] right)
//   Command        one-cycle Enter pulse
//   CursorX/Y      current cursor position
//   Held           a direction key is currently held
module cursor_nav_fsm
  import ps2_pkg::*;
#(
  parameter int COLS         = 16,
  parameter int ROWS         = 4,
  parameter int WRAP         = 1,
  parameter int REPEAT_DELAY = 25_000_000,
  parameter int REPEAT_RATE  = 5_000_000
) (
  input  logic                    Clock,
  input  logic                    nReset,
  input  logic                    Enable,
  input  logic [7:0]              data,
  input  logic                    data_en,
  output logic [3:0]              Direction,
  output logic                    Command,
  output logic [$clog2(COLS)-1:0] CursorX,
  output logic [$clog2(ROWS)-1:0] CursorY,
  output logic                    Held
);

  localparam int XW      = $clog2(COLS);
  localparam int YW      = $clog2(ROWS);
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int CW      = $clog2(RPT_MAX + 1);

  localparam logic [XW-1:0] X_MAX = XW'(COLS - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(ROWS - 1);
  // The counter holds the number of edges left until the next repeat edge.
  // Loading DELAY-1 at the make edge puts the first repeat pulse in cycle
  // T0+REPEAT_DELAY; reloading RATE at each repeat spaces the rest.
  localparam logic [CW-1:0] CNT_FIRST = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] CNT_NEXT  = CW'(REPEAT_RATE);

  logic       key_ev;
  logic       is_break;
  logic [2:0] key_id_raw;

  ps2_code_decoder u_dec (
    .clk      (Clock),
    .rst_n    (nReset),
    .enable   (Enable),
    .data     (data),
    .data_en  (data_en),
    .key_ev   (key_ev),
    .is_break (is_break),
    .key_id   (key_id_raw)
  );

  logic [3:0]    dir_q, dir_d;
  logic          cmd_q, cmd_d;
  logic          held_q, held_d;
  key_id_t       held_key_q, held_key_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  key_id_t       kid;
  key_id_t       move;

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      dir_q      <= DIR_NONE;
      cmd_q      <= 1'b0;
      held_q     <= 1'b0;
      held_key_q <= KEY_NONE;
      cnt_q      <= '0;
      x_q        <= '0;
      y_q        <= '0;
    end else begin
      dir_q      <= dir_d;
      cmd_q      <= cmd_d;
      held_q     <= held_d;
      held_key_q <= held_key_d;
      cnt_q      <= cnt_d;
      x_q        <= x_d;
      y_q        <= y_d;
    end
  end

  always_comb begin
    dir_d      = DIR_NONE;
    cmd_d      = 1'b0;
    held_d     = held_q;
    held_key_d = held_key_q;
    cnt_d      = cnt_q;
    x_d        = x_q;
    y_d        = y_q;
    move       = KEY_NONE;
    kid        = key_id_t'(key_id_raw);
    if (!Enable) begin
      held_d = 1'b0;
      cnt_d  = '0;
    end else begin
      // Auto-repeat first; a key event below may override it so that a
      // coincident break suppresses the pulse and a coincident make
      // produces exactly one pulse.
      if (held_q) begin
        if (cnt_q < CW'(2)) begin
          move  = held_key_q;
          cnt_d = CNT_NEXT;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      if (key_ev) begin
        if (kid == KEY_ENTER) begin
          if (!is_break) cmd_d = 1'b1;
        end else if (!is_break) begin
          // Typematic re-make of the held key is ignored.
          if (!(held_q && held_key_q == kid)) begin
            held_d     = 1'b1;
            held_key_d = kid;
            cnt_d      = CNT_FIRST;
            move       = kid;
          end
        end else if (held_q && held_key_q == kid) begin
          held_d = 1'b0;
          cnt_d  = '0;
          move   = KEY_NONE;
        end
      end
      dir_d = key_to_dir(move);
      case (move)
        KEY_UP:    y_d = (y_q == '0)    ? ((WRAP != 0) ? Y_MAX : '0)    : y_q - YW'(1);
        KEY_DOWN:  y_d = (y_q == Y_MAX) ? ((WRAP != 0) ? '0    : Y_MAX) : y_q + YW'(1);
        KEY_LEFT:  x_d = (x_q == '0)    ? ((WRAP != 0) ? X_MAX : '0)    : x_q - XW'(1);
        KEY_RIGHT: x_d = (x_q == X_MAX) ? ((WRAP != 0) ? '0    : X_MAX) : x_q + XW'(1);
        default: ;
      endcase
    end
  end

  assign Direction = dir_q;
  assign Command   = cmd_q;
  assign CursorX   = x_q;
  assign CursorY   = y_q;
  assign Held      = held_q;

endmodule

// File: tb/tb_cursor_nav_fsm.sv
module tb_cursor_nav_fsm;
  localparam int COLS = 16;
  localparam int ROWS = 4;
  localparam int RD   = 20;
  localparam int RR   = 5;

  logic       Clock   = 1'b0;
  logic       nReset  = 1'b0;
  logic       Enable  = 1'b0;
  logic [7:0] data    = 8'h00;
  logic       data_en = 1'b0;

  logic [3:0] dir_w, dir_c;
  logic       cmd_w, cmd_c, held_w, held_c;
  logic [3:0] x_w, x_c;
  logic [1:0] y_w, y_c;

  cursor_nav_fsm #(.COLS(COLS), .ROWS(ROWS), .WRAP(1), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)) dut_w (
    .Clock(Clock), .nReset(nReset), .Enable(Enable), .data(data), .data_en(data_en),
    .Direction(dir_w), .Command(cmd_w), .CursorX(x_w), .CursorY(y_w), .Held(held_w)
  );

  cursor_nav_fsm #(.COLS(COLS), .ROWS(ROWS), .WRAP(0), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)) dut_c (
    .Clock(Clock), .nReset(nReset), .Enable(Enable), .data(data), .data_en(data_en),
    .Direction(dir_c), .Command(cmd_c), .CursorX(x_c), .CursorY(y_c), .Held(held_c)
  );

  always #5 Clock = ~Clock;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model: keys as ints (0 up, 1 down, 2 left, 3 right, 4 enter),
  // pending prefix bytes in a queue, repeat timing from the make cycle.
  logic [7:0] seq[$];
  int         m_held_key = -1;
  int         t0 = 0;
  int         ex_w = 0, ey_w = 0, ex_c = 0, ey_c = 0;
  logic [3:0] e_dir = 4'b0;
  logic       e_cmd = 1'b0;

  function automatic int key_of(input logic [7:0] code, input bit ext);
    if (!ext) begin
      case (code)
        8'h1D: return 0;
        8'h1B: return 1;
        8'h1C: return 2;
        8'h23: return 3;
        8'h5A: return 4;
        default: return -1;
      endcase
    end
    case (code)
      8'h75: return 0;
      8'h72: return 1;
      8'h6B: return 2;
      8'h74: return 3;
      8'h5A: return 4;
      default: return -1;
    endcase
  endfunction

  task automatic model_reset();
    seq.delete();
    m_held_key = -1;
    ex_w = 0; ey_w = 0; ex_c = 0; ey_c = 0;
    e_dir = 4'b0; e_cmd = 1'b0;
  endtask

  task automatic model_step(input logic en, input logic de, input logic [7:0] b);
    int  mv;
    int  k;
    int  age;
    bit  ext;
    bit  brk;
    bit  pending;
    mv = -1;
    e_dir = 4'b0;
    e_cmd = 1'b0;
    if (!en) begin
      seq.delete();
      m_held_key = -1;
      return;
    end
    if (m_held_key >= 0) begin
      age = cyc - t0;
      if (age >= RD - 1 && ((age - (RD - 1)) % RR) == 0) mv = m_held_key;
    end
    if (de) begin
      seq.push_back(b);
      pending = (seq.size() == 1 && (b == 8'hE0 || b == 8'hF0)) ||
                (seq.size() == 2 && seq[0] == 8'hE0 && b == 8'hF0);
      if (!pending) begin
        ext = (seq[0] == 8'hE0);
        brk = (seq.size() > 1) && (seq[seq.size()-2] == 8'hF0);
        k = key_of(b, ext);
        seq.delete();
        if (k == 4) begin
          if (!brk) e_cmd = 1'b1;
        end else if (k >= 0) begin
          if (!brk) begin
            if (k != m_held_key) begin
              m_held_key = k;
              t0 = cyc;
              mv = k;
            end
          end else if (k == m_held_key) begin
            m_held_key = -1;
            mv = -1;
          end
        end
      end
    end
    if (mv >= 0) begin
      e_dir = 4'(1 << mv);
      case (mv)
        0: begin ey_w = (ey_w + ROWS - 1) % ROWS; ey_c = (ey_c > 0) ? ey_c - 1 : 0; end
        1: begin ey_w = (ey_w + 1) % ROWS; ey_c = (ey_c < ROWS - 1) ? ey_c + 1 : ey_c; end
        2: begin ex_w = (ex_w + COLS - 1) % COLS; ex_c = (ex_c > 0) ? ex_c - 1 : 0; end
        default: begin ex_w = (ex_w + 1) % COLS; ex_c = (ex_c < COLS - 1) ? ex_c + 1 : ex_c; end
      endcase
    end
  endtask

  task automatic tick(input logic [7:0] b, input logic de, input logic en);
    data = b; data_en = de; Enable = en;
    @(posedge Clock);
    model_step(en, de, b);
    cyc++;
    #1;
  endtask

  function automatic logic [23:0] got_all();
    return {dir_w, cmd_w, x_w, y_w, held_w, dir_c, cmd_c, x_c, y_c, held_c};
  endfunction

  function automatic logic [23:0] exp_all();
    logic h;
    h = (m_held_key >= 0);
    return {e_dir, e_cmd, 4'(ex_w), 2'(ey_w), h, e_dir, e_cmd, 4'(ex_c), 2'(ey_c), h};
  endfunction

  task automatic do_reset();
    data_en = 1'b0; Enable = 1'b1;
    #2 nReset = 1'b0;
    repeat (2) @(posedge Clock);
    #2 nReset = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    Enable = 1'b1;
    repeat (3) @(posedge Clock);
    #1;
    total++;
    if (got_all() !== 24'h0) begin
      bad++; $display("FAIL reset_state got=%h exp=%h", got_all(), 24'h0);
    end
    #1 nReset = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      tick(8'h00, 1'b0, 1'b1);
      total++;
      if (got_all() !== exp_all()) begin
        bad++; $display("FAIL reset_idle cyc=%0d got=%h exp=%h", cyc, got_all(), exp_all());
      end
    end
  endtask

  task automatic test_basic();
    logic [8:0] stim [8] = '{9'h123, 9'h000, 9'h000, 9'h1F0, 9'h123, 9'h000, 9'h000, 9'h000};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      tick(stim[i][7:0], stim[i][8], 1'b1);
      total++;
      if (got_all() !== exp_all()) begin
        bad++; $display("FAIL basic cyc=%0d got=%h exp=%h", cyc, got_all(), exp_all());
      end
      if (i == 0) begin
        total++;
        if (dir_w !== 4'b1000 || x_w !== 4'd1 || y_w !== 2'd0 || held_w !== 1'b1) begin
          bad++; $display("FAIL basic_make dir=%b x=%0d y=%0d held=%b exp dir=1000 x=1 y=0 held=1", dir_w, x_w, y_w, held_w);
        end
      end
    end
    total++;
    if (held_w !== 1'b0 || x_w !== 4'd1) begin
      bad++; $display("FAIL basic_break held=%b x=%0d exp held=0 x=1", held_w, x_w);
    end
  endtask

  task automatic test_edge_wrap();
    logic [7:0] stim [6] = '{8'hE0, 8'h6B, 8'hE0, 8'hF0, 8'h6B, 8'h00};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      tick(stim[i], (i != 5), 1'b1);
      total++;
      if (got_all() !== exp_all()) begin
        bad++; $display("FAIL edge_wrap cyc=%0d got=%h exp=%h", cyc, got_all(), exp_all());
      end
      if (i == 1) begin
        total++;
        if (x_w !== 4'd15 || x_c !== 4'd0 || dir_c !== 4'b0100 || dir_w !== 4'b0100) begin
          bad++; $display("FAIL edge_left xw=%0d xc=%0d dirw=%b dirc=%b exp 15 0 0100 0100", x_w, x_c, dir_w, dir_c);
        end
      end
    end
  endtask

  task automatic test_repeat();
    int pulses;
    do_reset();
    pulses = 0;
    for (int i = 0; i < 38; i++) begin
      tick((i == 0) ? 8'h1B : 8'h00, (i == 0), 1'b1);
      if (dir_w != 4'b0) pulses++;
      total++;
      if (got_all() !== exp_all()) begin
        bad++; $display("FAIL repeat cyc=%0d got=%h exp=%h", cyc, got_all(), exp_all());
      end
    end
    total++;
    if (pulses !== 5 || y_w !== 2'd1 || y_c !== 2'd3) begin
      bad++; $display("FAIL repeat_count pulses=%0d yw=%0d yc=%0d exp 5 1 3", pulses, y_w, y_c);
    end
    for (int i = 0; i < 12; i++) begin
      tick((i == 0) ? 8'hF0 : 8'h1B, (i < 2), 1'b1);
      total++;
      if (got_all() !== exp_all()) begin
        bad++; $display("FAIL repeat_break cyc=%0d got=%h exp=%h", cyc, got_all(), exp_all());
      end
    end
  endtask

  task automatic test_typematic();
    do_reset();
    for (int i = 0; i < 31; i++) begin
      tick(8'h1D, (i % 3 == 0), 1'b1);
      total++;
      if (got_all() !== exp_all()) begin
        bad++; $display("FAIL typematic cyc=%0d got=%h exp=%h", cyc, got_all(), exp_all());
      end
    end
    tick(8'h1C, 1'b1, 1'b1);
    total++;
    if (dir_w !== 4'b0100 || got_all() !== exp_all()) begin
      bad++; $display("FAIL typematic_switch dir=%b got=%h exp=%h", dir_w, got_all(), exp_all());
    end
    for (int i = 0; i < 30; i++) begin
      tick((i == 5) ? 8'hF0 : 8'h1D, (i == 5 || i == 6), 1'b1);
      total++;
      if (got_all() !== exp_all()) begin
        bad++; $display("FAIL typematic_hold cyc=%0d got=%h exp=%h", cyc, got_all(), exp_all());
      end
    end
    total++;
    if (held_w !== 1'b1) begin
      bad++; $display("FAIL typematic_held held=%b exp=1", held_w);
    end
  endtask

  task automatic test_enter();
    logic [8:0] stim [8] = '{9'h15A, 9'h000, 9'h1E0, 9'h112, 9'h000, 9'h1E0, 9'h15A, 9'h000};
    int cmds;
    do_reset();
    cmds = 0;
    for (int i = 0; i < 8; i++) begin
      tick(stim[i][7:0], stim[i][8], 1'b1);
      if (cmd_w) cmds++;
      total++;
      if (got_all() !== exp_all()) begin
        bad++; $display("FAIL enter cyc=%0d got=%h exp=%h", cyc, got_all(), exp_all());
      end
    end
    total++;
    if (cmds !== 2 || x_w !== 4'd0 || y_w !== 2'd0 || held_w !== 1'b0 || dir_w !== 4'b0) begin
      bad++; $display("FAIL enter_count cmds=%0d x=%0d y=%0d held=%b exp 2 0 0 0", cmds, x_w, y_w, held_w);
    end
  endtask

  task automatic test_enable();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      tick(8'h23, 1'b1, 1'b1);
      tick(8'hF0, 1'b1, 1'b1);
      tick(8'h23, 1'b1, 1'b1);
    end
    tick(8'h23, 1'b1, 1'b1);
    tick(8'h00, 1'b0, 1'b1);
    tick(8'hF0, 1'b1, 1'b1);
    total++;
    if (x_w !== 4'd7 || held_w !== 1'b1 || got_all() !== exp_all()) begin
      bad++; $display("FAIL enable_setup x=%0d held=%b got=%h exp=%h", x_w, held_w, got_all(), exp_all());
    end
    for (int i = 0; i < 30; i++) begin
      tick(8'h23, 1'($urandom_range(0, 1)), 1'b0);
      total++;
      if (dir_w !== 4'b0 || cmd_w !== 1'b0 || x_w !== 4'd7 || held_w !== 1'b0 || got_all() !== exp_all()) begin
        bad++; $display("FAIL enable_low cyc=%0d got=%h exp=%h", cyc, got_all(), exp_all());
      end
    end
    tick(8'h23, 1'b1, 1'b1);
    total++;
    if (dir_w !== 4'b1000 || x_w !== 4'd8 || got_all() !== exp_all()) begin
      bad++; $display("FAIL enable_resume dir=%b x=%0d got=%h exp=%h", dir_w, x_w, got_all(), exp_all());
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    tick(8'h1D, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) tick(8'h00, 1'b0, 1'b1);
    tick(8'hE0, 1'b1, 1'b1);
    data_en = 1'b0;
    #2 nReset = 1'b0;
    #1;
    total++;
    if (got_all() !== 24'h0) begin
      bad++; $display("FAIL async_reset got=%h exp=%h", got_all(), 24'h0);
    end
    repeat (2) @(posedge Clock);
    #2 nReset = 1'b1;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      tick((i == 0) ? 8'h75 : 8'h1D, (i < 2), 1'b1);
      total++;
      if (got_all() !== exp_all()) begin
        bad++; $display("FAIL async_after cyc=%0d got=%h exp=%h", cyc, got_all(), exp_all());
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] stim [12] = '{8'h1D, 8'h1B, 8'h1C, 8'h23, 8'hE0, 8'h74, 8'hF0, 8'h23,
                              8'h5A, 8'hE0, 8'hF0, 8'h74};
    do_reset();
    for (int i = 0; i < 14; i++) begin
      tick((i < 12) ? stim[i] : 8'h00, (i < 12), 1'b1);
      total++;
      if (got_all() !== exp_all()) begin
        bad++; $display("FAIL back_to_back cyc=%0d got=%h exp=%h", cyc, got_all(), exp_all());
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] pool [12] = '{8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h5A, 8'h75,
                              8'h72, 8'h6B, 8'h74, 8'hE0, 8'hF0, 8'h12};
    logic de, en;
    do_reset();
    for (int i = 0; i < 800; i++) begin
      de = ($urandom_range(0, 99) < ((i < 300) ? 60 : 12));
      en = ($urandom_range(0, 99) >= 3);
      tick(pool[$urandom_range(0, 11)], de, en);
      total++;
      if (got_all() !== exp_all()) begin
        bad++; $display("FAIL random cyc=%0d got=%h exp=%h", cyc, got_all(), exp_all());
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_edge_wrap();
    test_repeat();
    test_typematic();
    test_enter();
    test_enable();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
